// File: rtl/uart_core_cfg.sv
// UART core with compile-time frame format, internal loopback, and a
// single-word receive holding register with parity, framing and overrun status.
//
// Transmit handshake: a word is taken on a rising edge where tx_valid and
// tx_ready are both 1. tx_ready stays 0 from the next cycle until the last
// stop bit has been sent.
//
// Receive handshake: rx_valid stays 1, with rx_data and the error flags
// stable, until a cycle with rx_ack=1. rx_valid then drops on the next cycle,
// unless a new frame completes in that same cycle.
module uart_core_cfg #(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    input  logic                 loopback,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic [2:0]           tx_state_dbg,
    output logic [2:0]           rx_state_dbg
);

    localparam int RAW_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int BIT_CYCLES = (RAW_CYCLES < 4) ? 4 : RAW_CYCLES;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CW = $clog2(BIT_CYCLES);

    localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(HALF_CYCLES - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic          PAR_EN    = (PARITY_EN != 0);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t                 tx_state;
    logic [CW-1:0]          tx_cnt;
    logic [2:0]             tx_bit;
    logic [DATA_BITS-1:0]   tx_shift;
    logic                   tx_par;
    logic                   tx_line;

    // Transmit FSM: one bit period per state step, LSB first via a right shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
            tx_ready <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    if (tx_valid) begin
                        tx_shift <= tx_data;
                        tx_par   <= (^tx_data) ^ PAR_ODD;
                        tx_line  <= 1'b0;
                        tx_ready <= 1'b0;
                        tx_cnt   <= '0;
                        tx_state <= S_START;
                    end
                end
                default: begin
                    if (tx_cnt != CNT_LAST) begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end else begin
                        tx_cnt <= '0;
                        case (tx_state)
                            S_START: begin
                                tx_state <= S_DATA;
                                tx_bit   <= '0;
                                tx_line  <= tx_shift[0];
                            end
                            S_DATA: begin
                                if (tx_bit == DATA_LAST) begin
                                    tx_bit <= '0;
                                    if (PAR_EN) begin
                                        tx_state <= S_PARITY;
                                        tx_line  <= tx_par;
                                    end else begin
                                        tx_state <= S_STOP;
                                        tx_line  <= 1'b1;
                                    end
                                end else begin
                                    tx_bit   <= tx_bit + 1'b1;
                                    tx_shift <= tx_shift >> 1;
                                    tx_line  <= tx_shift[1];
                                end
                            end
                            S_PARITY: begin
                                tx_state <= S_STOP;
                                tx_line  <= 1'b1;
                            end
                            S_STOP: begin
                                if (tx_bit == STOP_LAST) begin
                                    tx_state <= S_IDLE;
                                    tx_ready <= 1'b1;
                                end else begin
                                    tx_bit <= tx_bit + 1'b1;
                                end
                            end
                            default: tx_state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    // The pin idles high while the frame is routed internally.
    assign tx           = tx_line | loopback;
    assign tx_state_dbg = tx_state;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic rx_s1, rx_s2, rx_src;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

    // Loopback taps the registered transmit line, so no synchroniser is needed.
    assign rx_src = loopback ? tx_line : rx_s2;

    state_t                 rx_state;
    logic [CW-1:0]          rx_cnt;
    logic [2:0]             rx_bit;
    logic [DATA_BITS-1:0]   rx_shift;
    logic                   rx_par_bit;
    logic                   rx_stop_bad;
    logic                   rx_prev;
    logic                   rx_done;
    logic                   new_perr;
    logic                   new_ferr;

    // Last stop-bit sample of the frame; the final stop sample is folded in directly.
    assign rx_done  = (rx_state == S_STOP) && (rx_cnt == CNT_LAST) && (rx_bit == STOP_LAST);
    assign new_perr = PAR_EN & (rx_par_bit ^ (^rx_shift) ^ PAR_ODD);
    assign new_ferr = rx_stop_bad | ~rx_src;

    // Receive FSM plus the holding register and its handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state      <= S_IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_shift      <= '0;
            rx_par_bit    <= 1'b0;
            rx_stop_bad   <= 1'b0;
            rx_prev       <= 1'b1;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_prev    <= rx_src;
            rx_overrun <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    if (rx_prev && !rx_src) begin
                        rx_state <= S_START;
                        rx_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (rx_cnt == CNT_HALF) begin
                        rx_cnt      <= '0;
                        rx_bit      <= '0;
                        rx_stop_bad <= 1'b0;
                        rx_state    <= rx_src ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_src, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == DATA_LAST) begin
                            rx_bit   <= '0;
                            rx_state <= PAR_EN ? S_PARITY : S_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt     <= '0;
                        rx_par_bit <= rx_src;
                        rx_state   <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt      <= '0;
                        rx_stop_bad <= rx_stop_bad | ~rx_src;
                        if (rx_bit == STOP_LAST) begin
                            rx_state <= S_IDLE;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase

            if (rx_done) begin
                if (!rx_valid || rx_ack) begin
                    rx_data       <= rx_shift;
                    rx_parity_err <= new_perr;
                    rx_frame_err  <= new_ferr;
                    rx_valid      <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_ack) begin
                rx_valid      <= 1'b0;
                rx_parity_err <= 1'b0;
                rx_frame_err  <= 1'b0;
            end
        end
    end

    assign rx_state_dbg = rx_state;

endmodule

// File: tb/tb_uart_core_cfg.sv
// Bench for uart_core_cfg: instance a is 8N1 in loopback, instance b is 8E2
// with its receive line driven directly by the bench. 1 MHz clock, 100 kbaud,
// so every bit lasts 10 clocks.
module tb_uart_core_cfg;

    logic clk;
    logic rst;

    // Instance a: 8N1, loopback
    logic       a_tx_valid, a_tx_ready, a_tx, a_rx, a_loopback, a_rx_valid, a_rx_ack;
    logic [7:0] a_tx_data, a_rx_data;
    logic       a_perr, a_ferr, a_ovr;
    logic [2:0] a_tx_st, a_rx_st;

    // Instance b: 8E2, external line
    logic       b_tx_valid, b_tx_ready, b_tx, b_rx, b_loopback, b_rx_valid, b_rx_ack;
    logic [7:0] b_tx_data, b_rx_data;
    logic       b_perr, b_ferr, b_ovr;
    logic [2:0] b_tx_st, b_rx_st;

    int total = 0;
    int bad   = 0;
    int ovr_seen = 0;

    uart_core_cfg #(
        .CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
        .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .rst(rst),
        .tx_valid(a_tx_valid), .tx_data(a_tx_data), .tx_ready(a_tx_ready), .tx(a_tx),
        .rx(a_rx), .loopback(a_loopback),
        .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ack(a_rx_ack),
        .rx_parity_err(a_perr), .rx_frame_err(a_ferr), .rx_overrun(a_ovr),
        .tx_state_dbg(a_tx_st), .rx_state_dbg(a_rx_st)
    );

    uart_core_cfg #(
        .CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
        .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)
    ) dut_b (
        .clk(clk), .rst(rst),
        .tx_valid(b_tx_valid), .tx_data(b_tx_data), .tx_ready(b_tx_ready), .tx(b_tx),
        .rx(b_rx), .loopback(b_loopback),
        .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ack(b_rx_ack),
        .rx_parity_err(b_perr), .rx_frame_err(b_ferr), .rx_overrun(b_ovr),
        .tx_state_dbg(b_tx_st), .rx_state_dbg(b_rx_st)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count overrun pulses on instance b
    always @(negedge clk) if (b_ovr) ovr_seen <= ovr_seen + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Serialise one 8E2 frame onto b_rx; rx_ack is raised for the single
    // cycle index ack_cyc (negative disables it).
    task automatic send_b(input logic [7:0] d, input logic flip_par,
                          input logic bad_stop, input int ack_cyc);
        logic [11:0] bits;
        bits = {1'b1, ~bad_stop, (^d) ^ flip_par, d, 1'b0};
        for (int c = 0; c < 120; c++) begin
            b_rx     = bits[c / 10];
            b_rx_ack = (c == ack_cyc);
            @(negedge clk);
        end
        b_rx     = 1'b1;
        b_rx_ack = 1'b0;
    endtask

    task automatic wait_b_valid(input int max_cycles);
        int n;
        n = 0;
        while (!b_rx_valid && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("rx_valid_wait", {31'd0, b_rx_valid}, 32'd1);
    endtask

    task automatic ack_b();
        b_rx_ack = 1'b1;
        @(negedge clk);
        b_rx_ack = 1'b0;
        check("rx_valid_after_ack", {31'd0, b_rx_valid}, 32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       flip_par;
        logic       bad_stop;
        logic       exp_perr;
        logic       exp_ferr;
    } rx_vec_t;

    rx_vec_t     vecs[6];
    int          first_k;
    int          tx_low;
    int          ovr_base;
    logic [119:0] obs;
    logic [11:0]  b2_exp;

    initial begin
        vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h81, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'hC6, 1'b0, 1'b0, 1'b0, 1'b0};
        // 0x03, 8E2: start, 1,1,0,0,0,0,0,0, parity 0, stop, stop (index 0 first)
        b2_exp = 12'b1100_0000_0110;

        rst = 1'b0;
        a_tx_valid = 1'b0; a_tx_data = 8'h00; a_rx = 1'b1; a_loopback = 1'b1; a_rx_ack = 1'b0;
        b_tx_valid = 1'b0; b_tx_data = 8'h00; b_rx = 1'b1; b_loopback = 1'b0; b_rx_ack = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_a_tx", {31'd0, a_tx}, 32'd1);
        check("reset_a_tx_ready", {31'd0, a_tx_ready}, 32'd1);
        check("reset_b_tx", {31'd0, b_tx}, 32'd1);
        check("reset_b_rx_valid", {31'd0, b_rx_valid}, 32'd0);
        check("reset_b_rx_data", {24'd0, b_rx_data}, 32'd0);
        check("reset_b_flags", {29'd0, b_perr, b_ferr, b_ovr}, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Loopback 8N1: 0xA5 returns 96 clocks after acceptance
        // (95 to the last stop-sample + 1 clock to register the falling edge).
        a_tx_valid = 1'b1; a_tx_data = 8'hA5;
        @(negedge clk);
        a_tx_valid = 1'b0;
        first_k = -1;
        tx_low  = 0;
        for (int k = 0; k < 130; k++) begin
            if (a_rx_valid && first_k < 0) first_k = k;
            if (a_tx !== 1'b1) tx_low++;
            @(negedge clk);
        end
        check("loop_tx_pin_high", tx_low, 0);
        check("loop_rx_latency", first_k, 96);
        check("loop_rx_data", {24'd0, a_rx_data}, 32'h0000_00A5);
        check("loop_flags", {29'd0, a_perr, a_ferr, a_ovr}, 32'd0);
        a_rx_ack = 1'b1;
        @(negedge clk);
        a_rx_ack = 1'b0;
        check("loop_ack", {31'd0, a_rx_valid}, 32'd0);

        // 8E2 transmit of 0x03; tx_data is changed mid-frame and must not matter
        b_tx_valid = 1'b1; b_tx_data = 8'h03;
        @(negedge clk);
        b_tx_valid = 1'b0;
        for (int k = 0; k <= 120; k++) begin
            if (k < 120) obs[k] = b_tx;
            if (k == 5) b_tx_data = 8'hFF;
            if (k == 0) check("tx_ready_busy", {31'd0, b_tx_ready}, 32'd0);
            if (k == 119) check("tx_ready_last", {31'd0, b_tx_ready}, 32'd0);
            if (k == 120) check("tx_ready_back", {31'd0, b_tx_ready}, 32'd1);
            @(negedge clk);
        end
        for (int i = 0; i < 12; i++) begin
            check($sformatf("tx_bit%0d", i), {22'd0, obs[i*10 +: 10]}, {22'd0, {10{b2_exp[i]}}});
        end

        // Receive vectors, including bad parity and bad stop followed by a good frame
        for (int v = 0; v < 6; v++) begin
            send_b(vecs[v].data, vecs[v].flip_par, vecs[v].bad_stop, -1);
            wait_b_valid(40);
            check($sformatf("vec%0d_data", v), {24'd0, b_rx_data}, {24'd0, vecs[v].data});
            check($sformatf("vec%0d_perr", v), {31'd0, b_perr}, {31'd0, vecs[v].exp_perr});
            check($sformatf("vec%0d_ferr", v), {31'd0, b_ferr}, {31'd0, vecs[v].exp_ferr});
            ack_b();
        end

        // Overrun: second frame with no ack is discarded
        ovr_base = ovr_seen;
        send_b(8'h11, 1'b0, 1'b0, -1);
        send_b(8'h22, 1'b0, 1'b0, -1);
        repeat (5) @(negedge clk);
        check("ovr_data_kept", {24'd0, b_rx_data}, 32'h11);
        check("ovr_valid", {31'd0, b_rx_valid}, 32'd1);
        check("ovr_pulses", ovr_seen - ovr_base, 1);
        ack_b();

        // Ack coincident with completion (edge 118 after the start bit is driven)
        send_b(8'h33, 1'b0, 1'b0, -1);
        ovr_base = ovr_seen;
        send_b(8'h44, 1'b0, 1'b0, 117);
        repeat (5) @(negedge clk);
        check("coinc_data", {24'd0, b_rx_data}, 32'h44);
        check("coinc_valid", {31'd0, b_rx_valid}, 32'd1);
        check("coinc_no_ovr", ovr_seen - ovr_base, 0);
        ack_b();

        // 3-clock glitch is rejected
        b_rx = 1'b0;
        repeat (3) @(negedge clk);
        b_rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_no_valid", {31'd0, b_rx_valid}, 32'd0);
        check("glitch_rx_idle", {29'd0, b_rx_st}, 32'd0);

        // Reset in the middle of the data bits
        a_tx_valid = 1'b1; a_tx_data = 8'h5A;
        b_tx_valid = 1'b1; b_tx_data = 8'h5A;
        @(negedge clk);
        a_tx_valid = 1'b0; b_tx_valid = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_b_tx", {31'd0, b_tx}, 32'd1);
        check("rst_tx_ready", {30'd0, a_tx_ready, b_tx_ready}, 32'd3);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (150) @(negedge clk);
        check("rst_no_rx_valid", {30'd0, a_rx_valid, b_rx_valid}, 32'd0);
        check("rst_fsms_idle", {20'd0, a_tx_st, a_rx_st, b_tx_st, b_rx_st}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
